// File: rtl/se_ctl_pkg.sv
// Shared types and constants for the SE16_32 arbiter slice.
package se_ctl_pkg;

   localparam int NUM_REQ = 2;

   typedef enum logic [1:0] {
      SIGN   = 2'b00,
      ZERO   = 2'b01,
      LUI    = 2'b10,
      BRANCH = 2'b11
   } ext_mode_t;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } arb_state_t;

endpackage

// File: rtl/se16_32_arbiter_se16_32.sv
// Shared 16-to-32 bit sign extender.
module SE16_32 (
   input  logic [15:0] i_imm,
   output logic [31:0] o_ext
);

   assign o_ext = {{16{i_imm[15]}}, i_imm};

endmodule

// File: rtl/se16_32_arbiter.sv
// Round-robin arbiter sharing one SE16_32 between the ALU-immediate
// requester (0) and the branch-offset requester (1), with a one-entry
// registered result stage and saturating per-requester grant counters.
module se16_32_arbiter
   import se_ctl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req_valid,
   output logic [NUM_REQ-1:0] req_ready,
   input  logic [15:0]        req_imm0,
   input  logic [15:0]        req_imm1,
   input  logic [1:0]         req_mode0,
   input  logic [1:0]         req_mode1,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_data,
   output logic               out_id,
   output logic [CNT_W-1:0]   grant_cnt0,
   output logic [CNT_W-1:0]   grant_cnt1
);

   arb_state_t       r_state;
   logic             r_rr;
   logic [31:0]      r_data;
   logic             r_id;
   logic [CNT_W-1:0] r_cnt0;
   logic [CNT_W-1:0] r_cnt1;

   logic             w_winner;
   logic             w_canAccept;
   logic             w_xfer;
   logic [15:0]      w_imm;
   ext_mode_t        w_mode;
   logic [31:0]      w_ext;
   logic [31:0]      w_result;

   // A lone requester wins outright; on a tie the round-robin pointer decides.
   always_comb begin
      w_winner = r_rr;
      if (req_valid == 2'b01) begin
         w_winner = 1'b0;
      end else if (req_valid == 2'b10) begin
         w_winner = 1'b1;
      end
   end

   assign w_canAccept = (r_state == EMPTY) | out_ready;
   assign w_xfer      = w_canAccept & req_valid[w_winner];
   assign req_ready   = w_canAccept ? (w_winner ? 2'b10 : 2'b01) : 2'b00;

   assign w_imm  = w_winner ? req_imm1 : req_imm0;
   assign w_mode = ext_mode_t'(w_winner ? req_mode1 : req_mode0);

   SE16_32 u_se (
      .i_imm (w_imm),
      .o_ext (w_ext)
   );

   // Mode mux around the shared extender; branch offsets drop the top two bits.
   always_comb begin
      w_result = w_ext;
      case (w_mode)
         SIGN:    w_result = w_ext;
         ZERO:    w_result = {16'h0000, w_imm};
         LUI:     w_result = {w_imm, 16'h0000};
         BRANCH:  w_result = {w_ext[29:0], 2'b00};
         default: w_result = w_ext;
      endcase
   end

   // Result-register FSM: load on every transfer, drain when the consumer takes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= EMPTY;
         r_rr    <= 1'b0;
         r_data  <= 32'h0;
         r_id    <= 1'b0;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_xfer) begin
                  r_data  <= w_result;
                  r_id    <= w_winner;
                  r_rr    <= ~w_winner;
                  r_state <= FULL;
               end
            end
            FULL: begin
               if (w_xfer) begin
                  r_data  <= w_result;
                  r_id    <= w_winner;
                  r_rr    <= ~w_winner;
                  r_state <= FULL;
               end else if (out_ready) begin
                  r_state <= EMPTY;
               end
            end
            default: r_state <= EMPTY;
         endcase
      end
   end

   // Per-requester grant counters that stick at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else if (w_xfer) begin
         if (!w_winner && (r_cnt0 != '1)) begin
            r_cnt0 <= r_cnt0 + CNT_W'(1);
         end
         if (w_winner && (r_cnt1 != '1)) begin
            r_cnt1 <= r_cnt1 + CNT_W'(1);
         end
      end
   end

   assign out_valid  = (r_state == FULL);
   assign out_data   = r_data;
   assign out_id     = r_id;
   assign grant_cnt0 = r_cnt0;
   assign grant_cnt1 = r_cnt1;

endmodule

// File: doc/se16_32_arbiter.md
# se16_32_arbiter

Shares a single `SE16_32` sign-extension unit between two immediate consumers in the datapath: requester 0 is the ALU immediate path and requester 1 is the branch-offset path. The block arbitrates round-robin between the two and applies the per-request extension mode around the shared extender. It returns each result through a one-entry registered output stage with a valid/ready handshake, and keeps saturating per-requester grant counters for debug.

## Interface
Parameters:
- `CNT_W`, 16: width of each grant counter.

Ports (the clock is `clk`; reset is `rst_n`, asynchronous and active-low):
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  2  per-requester request valid; bit k belongs to requester k.
- `req_ready`  out  2  per-requester accept. A request transfers when valid and ready are both 1.
- `req_imm0`, `req_imm1`  in  16 each  immediate field for each requester.
- `req_mode0`, `req_mode1`  in  2 each  extension mode for each requester:
  - 00: SIGN, sign-extend.
  - 01: ZERO, zero-extend.
  - 10: LUI, `{imm,16'h0000}`.
  - 11: BRANCH, sign-extend then shift left by 2.
- `out_valid`  out  1  the result register holds a result.
- `out_ready`  in  1  the consumer accepts the result.
- `out_data`  out  32  extended value.
- `out_id`  out  1  index of the requester that produced `out_data`.
- `grant_cnt0`, `grant_cnt1`  out  `CNT_W` each  number of accepted transfers per requester; saturates at all-ones.

## Operation
- FSM states:
  - EMPTY: the result register is free.
  - FULL: the result register holds an undelivered result.
- Arbitration:
  - The round-robin pointer `rr` names the requester that has priority.
  - If only one requester is valid, it wins.
  - If both are valid, `rr` wins.
  - After every accepted transfer, `rr` moves to the other requester (the loser of that arbitration).
- Accept condition: `can_accept = (state==EMPTY) | out_ready`.
  - `req_ready[k] = can_accept & (winner==k)`.
  - `req_ready` is combinational from `req_valid`, `state` and `out_ready`.
  - At most one bit of `req_ready` is 1 in any cycle.
- Datapath:
  - The winner's imm feeds the shared `SE16_32` extender.
  - The winner's mode then selects the final value:
    - SIGN: `S`.
    - ZERO: `{16'h0,imm}`.
    - LUI: `{imm,16'h0}`.
    - BRANCH: `{S[29:0],2'b00}`. The top 2 bits are discarded; no overflow flag is produced.
- On a transfer: capture `out_data` and `out_id`, increment that requester's counter (no increment once saturated), and go to FULL.
- In FULL:
  - With `out_ready=1` and no new transfer: go to EMPTY.
  - With `out_ready=1` and a new transfer in the same cycle: stay FULL and load the new result.
  - With `out_ready=0`: hold `out_data` and `out_id` stable and drive `req_ready=0`.
- Requester inputs are ignored whenever their ready is 0. Requests are never lost or duplicated.
- Reset (asynchronous, at any time, including mid-transfer):
  - State goes to EMPTY, `rr=0`, `out_valid=0`, `out_data=0`, `out_id=0`, counters 0.
  - Any in-flight result is discarded.

## Timing
- Latency is 1 cycle: a request accepted at edge N appears with `out_valid=1` after edge N.
- Throughput is 1 result per cycle while `out_ready` stays 1.
- Simultaneous valids with a continuously ready consumer: grants alternate 0,1,0,1…
- No combinational path from the `req_*` data/mode inputs to `out_*`. All outputs except `req_ready` are registered.
- Reset is asserted asynchronously and released synchronously with respect to `clk`. The first grant can occur on the first edge after release.

## Structure
- Package `se_ctl_pkg` holds:
  - `ext_mode_t` enum (SIGN, ZERO, LUI, BRANCH).
  - `arb_state_t` enum (EMPTY, FULL).
  - Requester count constant `NUM_REQ=2`.
- Exactly one sub-module: the existing `SE16_32` component, instantiated once and shared by both requesters. The mode mux and shift sit around it in this block.
- The arbiter, FSM, output register and counters live in this module.

## Test plan
- Requester 0 only, imm=3782, SIGN; expected on the cycle after accept:
  - `out_data=32'h00000EC6`, `out_id=0`.
- Requester 1 only, imm=16'hFFD5 (-43), one request per mode:
  - SIGN → `32'hFFFFFFD5`.
  - ZERO → `32'h0000FFD5`.
  - BRANCH → `32'hFFFFFF54`.
  - Requester 0, imm=16'h1234, LUI → `32'h12340000`.
- Both requesters valid for 4 cycles with `out_ready=1` from reset:
  - `out_id` sequence 0,1,0,1.
  - `grant_cnt0=2`, `grant_cnt1=2`.
- Backpressure: hold `out_ready=0` for 3 cycles while FULL.
  - `out_data` and `out_id` stay stable and `req_ready=2'b00`.
  - Raise `out_ready` with requester 1 valid: back-to-back load, `out_valid` stays 1.
- Reset mid-operation: assert `rst_n=0` while FULL.
  - Immediately: `out_valid=0`, `out_data=0`, counters 0.
  - After release, the first simultaneous request grants requester 0.
- Saturation: build with `CNT_W=2` and make 5 requester-0 transfers; `grant_cnt0` reaches 3 and stays at 3.
